// File: rtl/reg_bank_seq.sv
// reg_bank_seq: sequenced register bank (LOAD/MOV/SWAP/CLR) with two registered read ports.
// Build option REG_BANK_BYPASS_EN: read ports forward write data landing on the same edge.
module reg_bank_seq #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_src,
  input  logic [WIDTH-1:0] from_bus,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | ready to accept a command
  // EXEC  | single write of LOAD/MOV/CLR, or first SWAP write reg[dst] <= reg[src]
  // SWAP2 | second SWAP write reg[src] <= temp
  typedef enum logic [1:0] {IDLE, EXEC, SWAP2} state_e;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_e           state;
  logic [1:0]       op_q;
  logic [AW-1:0]    dst_q;
  logic [AW-1:0]    src_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] temp_q;
  logic [WIDTH-1:0] regs [DEPTH];

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Indices past the bank read as zero.
  function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
    return in_range(a) ? regs[a] : '0;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = dst_q;
    wr_data = '0;
    case (state)
      EXEC: begin
        wr_addr = dst_q;
        wr_en   = in_range(dst_q);
        case (op_q)
          OP_LOAD: wr_data = data_q;
          OP_MOV:  wr_data = rd(src_q);
          OP_SWAP: wr_data = rd(src_q);
          OP_CLR:  wr_data = '0;
          default: wr_data = '0;
        endcase
      end
      SWAP2: begin
        wr_addr = src_q;
        wr_en   = in_range(src_q);
        wr_data = temp_q;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_LOAD;
      dst_q  <= '0;
      src_q  <= '0;
      data_q <= '0;
      temp_q <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            dst_q  <= cmd_dst;
            src_q  <= cmd_src;
            data_q <= from_bus;
            temp_q <= rd(cmd_dst);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_SWAP) begin
            state <= SWAP2;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        SWAP2: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      r0 <= '0;
      r1 <= '0;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
`ifdef REG_BANK_BYPASS_EN
      r0 <= (wr_en && wr_addr == ra_addr) ? wr_data : rd(ra_addr);
      r1 <= (wr_en && wr_addr == rb_addr) ? wr_data : rd(rb_addr);
`else
      r0 <= rd(ra_addr);
      r1 <= rd(rb_addr);
`endif
    end
  end

endmodule

// File: tb/tb_reg_bank_seq.sv
// tb_reg_bank_seq: directed stimulus for reg_bank_seq (DEPTH=6) with a cycle-level reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_reg_bank_seq;
  localparam int DEPTH = 6;
`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_dst = 3'd0;
  logic [2:0]  cmd_src = 3'd0;
  logic [15:0] from_bus = 16'h0;
  logic [2:0]  ra_addr = 3'd0;
  logic [2:0]  rb_addr = 3'd0;
  logic [15:0] r0, r1;
  logic        busy, done;

  int total = 0;
  int bad = 0;

  reg_bank_seq #(.WIDTH(16), .DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .from_bus(from_bus),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .r0(r0), .r1(r1), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted command becomes a list of scheduled writes.
  logic [15:0] m_reg [8];
  logic [15:0] m_pre [8];
  int cyc = 0;
  int last_final = -1;
  int w1_e = -1, w2_e = -1;
  logic [2:0]  w1_a, w2_a;
  logic [15:0] w1_d, w2_d;
  logic [15:0] exp_r0 = 16'h0, exp_r1 = 16'h0;
  logic exp_done = 1'b0, exp_ready = 1'b1;

  initial for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
      last_final = cyc;
      w1_e = -1;
      w2_e = -1;
      exp_r0 = 16'h0;
      exp_r1 = 16'h0;
      exp_done = 1'b0;
      exp_ready = 1'b1;
    end else begin
      cyc++;
      m_pre = m_reg;
      if (cyc == w1_e && int'(w1_a) < DEPTH) m_reg[w1_a] = w1_d;
      if (cyc == w2_e && int'(w2_a) < DEPTH) m_reg[w2_a] = w2_d;
      exp_done = (cyc == last_final);
      if (cmd_valid && cyc >= last_final + 1) begin
        w1_e = cyc + 1;
        w1_a = cmd_dst;
        w2_e = -1;
        last_final = cyc + 1;
        case (cmd_op)
          2'b00: w1_d = from_bus;
          2'b01: w1_d = (int'(cmd_src) < DEPTH) ? m_reg[cmd_src] : 16'h0;
          2'b10: begin
            w1_d = (int'(cmd_src) < DEPTH) ? m_reg[cmd_src] : 16'h0;
            w2_e = cyc + 2;
            w2_a = cmd_src;
            w2_d = (int'(cmd_dst) < DEPTH) ? m_reg[cmd_dst] : 16'h0;
            last_final = cyc + 2;
          end
          default: w1_d = 16'h0;
        endcase
      end
      if (BYP) begin
        exp_r0 = (int'(ra_addr) < DEPTH) ? m_reg[ra_addr] : 16'h0;
        exp_r1 = (int'(rb_addr) < DEPTH) ? m_reg[rb_addr] : 16'h0;
      end else begin
        exp_r0 = (int'(ra_addr) < DEPTH) ? m_pre[ra_addr] : 16'h0;
        exp_r1 = (int'(rb_addr) < DEPTH) ? m_pre[rb_addr] : 16'h0;
      end
      exp_ready = (cyc >= last_final);
    end
  end

  always @(negedge clk) begin
    chk("model_r0", {16'h0, r0}, {16'h0, exp_r0});
    chk("model_r1", {16'h0, r1}, {16'h0, exp_r1});
    chk("model_done", {31'h0, done}, {31'h0, exp_done});
    chk("model_ready", {31'h0, cmd_ready}, {31'h0, exp_ready});
    chk("model_busy", {31'h0, busy}, {31'h0, ~exp_ready});
  end

  // Presents a command from posedge+2 and drops valid right after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                      input logic [15:0] data, input int hold_extra);
    bit rdy;
    bit ok = 1'b0;
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; from_bus = data;
    for (int n = 0; n < 20; n++) begin
      rdy = cmd_ready;
      @(posedge clk); #2;
      if (rdy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      bad++; total++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
    repeat (hold_extra) begin @(posedge clk); #2; end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'h0, cmd_ready}, 32'h1);
    chk("reset_r0", {16'h0, r0}, 32'h0);

    // LOAD BEEF into reg3, read on port A
    ra_addr = 3'd3;
    send(2'b00, 3'd3, 3'd0, 16'hBEEF, 0);
    @(negedge clk);
    chk("load_done_k", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("load_done_k1", {31'h0, done}, 32'h1);
    chk("load_r0_k1", {16'h0, r0}, BYP ? 32'hBEEF : 32'h0);
    @(negedge clk);
    chk("load_r0_k2", {16'h0, r0}, 32'hBEEF);
    chk("load_done_k2", {31'h0, done}, 32'h0);

    // SWAP reg1/reg2
    send(2'b00, 3'd1, 3'd0, 16'h1111, 0);
    send(2'b00, 3'd2, 3'd0, 16'h2222, 0);
    send(2'b10, 3'd1, 3'd2, 16'h0, 0);
    @(negedge clk);
    chk("swap_busy_k", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("swap_busy_k1", {31'h0, busy}, 32'h1);
    chk("swap_done_k1", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("swap_busy_k2", {31'h0, busy}, 32'h0);
    chk("swap_done_k2", {31'h0, done}, 32'h1);
    ra_addr = 3'd1; rb_addr = 3'd2;
    repeat (2) @(negedge clk);
    chk("swap_reg1", {16'h0, r0}, 32'h2222);
    chk("swap_reg2", {16'h0, r1}, 32'h1111);

    // self MOV with valid held through BUSY, self SWAP
    send(2'b00, 3'd5, 3'd0, 16'h5555, 0);
    send(2'b00, 3'd4, 3'd0, 16'h4444, 0);
    send(2'b01, 3'd5, 3'd5, 16'h0, 1);
    send(2'b10, 3'd4, 3'd4, 16'h0, 0);
    ra_addr = 3'd5; rb_addr = 3'd4;
    repeat (4) @(negedge clk);
    chk("mov_self", {16'h0, r0}, 32'h5555);
    chk("swap_self", {16'h0, r1}, 32'h4444);

    // back-to-back LOAD then CLR of reg0
    rb_addr = 3'd0;
    send(2'b00, 3'd0, 3'd0, 16'h00AA, 0);
    send(2'b11, 3'd0, 3'd0, 16'h0, 0);
    @(negedge clk);
    chk("b2b_r1_k", {16'h0, r1}, 32'h00AA);
    @(negedge clk);
    chk("b2b_r1_k1", {16'h0, r1}, BYP ? 32'h0 : 32'h00AA);
    chk("b2b_done", {31'h0, done}, 32'h1);
    @(negedge clk);
    chk("b2b_r1_k2", {16'h0, r1}, 32'h0);

    // out-of-range destination
    ra_addr = 3'd7; rb_addr = 3'd3;
    send(2'b00, 3'd7, 3'd0, 16'h7777, 0);
    repeat (3) @(negedge clk);
    chk("oor_r0", {16'h0, r0}, 32'h0);
    chk("oor_reg3", {16'h0, r1}, 32'hBEEF);

    // reset mid-SWAP after its first write
    ra_addr = 3'd1; rb_addr = 3'd2;
    send(2'b10, 3'd1, 3'd2, 16'h0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_r0", {16'h0, r0}, 32'h0);
    chk("rst_r1", {16'h0, r1}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ready", {31'h0, cmd_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_reg1", {16'h0, r0}, 32'h0);
    chk("rst_reg2", {16'h0, r1}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
